conv_feeder: RTL and testbench

//  Transmit side of the conv_mix input interface. Fetches one layer's 5x5 binary kernel and

---
 rtl/conv_feed_pkg.sv | 28 ++
 rtl/conv_feeder.sv | 162 ++++++++++++++++
 tb/tb_conv_feeder.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/conv_feed_pkg.sv
// Shared constants and FSM encoding for the conv_mix feeder.
package conv_feed_pkg;

  localparam int DW     = 32;
  localparam int K      = 5;
  localparam int KK     = K * K;
  localparam int IMG_W0 = 28;
  localparam int IMG_W1 = 12;
  localparam int N0     = IMG_W0 * IMG_W0;
  localparam int N1     = IMG_W1 * IMG_W1;
  localparam int AW     = 10;

  localparam logic [AW-1:0] A_ONE    = 10'd1;
  localparam logic [AW-1:0] A_N0     = 10'd784;
  localparam logic [AW-1:0] A_N1     = 10'd144;
  localparam logic [4:0]    BIT_LAST = 5'd24;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WFETCH = 3'd1,
    S_WLOAD  = 3'd2,
    S_PRIME  = 3'd3,
    S_STREAM = 3'd4,
    S_DRAIN  = 3'd5,
    S_FIN    = 3'd6
  } feed_state_e;

endpackage

// File: rtl/conv_feeder.sv
// Feeds one layer's 5x5 binary kernel and image from sync-read RAMs into conv_mix.
// Optional FEED_STATS_EN adds saturating ovr_cnt / stall_cnt observability counters.
module conv_feeder
  import conv_feed_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          layer,
  output logic          wgt_rd,
  output logic [AW-1:0] wgt_raddr,
  input  logic [DW-1:0] wgt_rdata,
  output logic          img_rd,
  output logic [AW-1:0] img_raddr,
  input  logic [DW-1:0] img_rdata,
  output logic          conv_start,
  output logic          weight_en,
  output logic          weight,
  output logic [DW-1:0] din,
  output logic          state,
  input  logic          din_ready,
  input  logic          conv_done,
  output logic          busy,
  output logic          done,
  output logic          short_err
`ifdef FEED_STATS_EN
  ,
  output logic [15:0]   ovr_cnt,
  output logic [15:0]   stall_cnt
`endif
);

  feed_state_e   r_st;
  feed_state_e   w_st_nxt;
  logic [4:0]    r_bit_cnt;
  logic [AW-1:0] r_pix_cnt;
  logic [AW-1:0] w_n_pix;
  logic          r_layer;
  logic          r_short_err;
  logic [DW-1:0] r_din;
  logic          w_accept;
  logic          w_unused;

  assign w_unused = &{1'b0, wgt_rdata[DW-2:0]};
  assign w_n_pix  = r_layer ? A_N1 : A_N0;
  assign w_accept = (r_st == S_STREAM) && din_ready && (r_pix_cnt != w_n_pix);

  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      S_IDLE:   if (start) w_st_nxt = S_WFETCH; else w_st_nxt = S_IDLE;
      S_WFETCH: w_st_nxt = S_WLOAD;
      S_WLOAD:  if (r_bit_cnt == BIT_LAST) w_st_nxt = S_PRIME; else w_st_nxt = S_WLOAD;
      S_PRIME:  w_st_nxt = S_STREAM;
      // An early conv_done cuts the stream short and is flagged as short_err.
      S_STREAM: begin
        if (conv_done)
          w_st_nxt = S_FIN;
        else if (din_ready && (r_pix_cnt == w_n_pix - A_ONE))
          w_st_nxt = S_DRAIN;
        else
          w_st_nxt = S_STREAM;
      end
      S_DRAIN:  if (conv_done) w_st_nxt = S_FIN; else w_st_nxt = S_DRAIN;
      S_FIN:    w_st_nxt = S_IDLE;
      default:  w_st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_st <= S_IDLE;
    else       r_st <= w_st_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_layer     <= 1'b0;
      r_short_err <= 1'b0;
      r_bit_cnt   <= 5'd0;
      r_pix_cnt   <= {AW{1'b0}};
      r_din       <= {DW{1'b0}};
    end else if (r_st == S_IDLE) begin
      if (start) begin
        r_layer     <= layer;
        r_short_err <= 1'b0;
        r_bit_cnt   <= 5'd0;
        r_pix_cnt   <= {AW{1'b0}};
      end
    end else begin
      if (r_st == S_WLOAD && r_bit_cnt != BIT_LAST)
        r_bit_cnt <= r_bit_cnt + 5'd1;
      if (w_accept) begin
        r_din     <= img_rdata;
        r_pix_cnt <= r_pix_cnt + A_ONE;
      end
      if (r_st == S_STREAM && conv_done)
        r_short_err <= 1'b1;
    end
  end

  // RAM strobes run one address ahead of the beat being consumed so reads never bubble.
  always_comb begin
    wgt_rd    = 1'b0;
    wgt_raddr = {AW{1'b0}};
    img_rd    = 1'b0;
    img_raddr = {AW{1'b0}};
    case (r_st)
      S_WFETCH: wgt_rd = 1'b1;
      S_WLOAD: begin
        if (r_bit_cnt != BIT_LAST) begin
          wgt_rd    = 1'b1;
          wgt_raddr = {{(AW-5){1'b0}}, r_bit_cnt} + A_ONE;
        end else begin
          wgt_rd    = 1'b0;
        end
      end
      S_PRIME:  img_rd = 1'b1;
      S_STREAM: begin
        if (din_ready && (r_pix_cnt < w_n_pix - A_ONE)) begin
          img_rd    = 1'b1;
          img_raddr = r_pix_cnt + A_ONE;
        end else begin
          img_rd    = 1'b0;
        end
      end
      default:  img_rd = 1'b0;
    endcase
  end

  assign weight_en  = (r_st == S_WLOAD);
  assign weight     = (r_st == S_WLOAD) & ~wgt_rdata[DW-1];
  assign conv_start = (r_st != S_IDLE) && (r_st != S_FIN);
  assign busy       = (r_st != S_IDLE);
  assign done       = (r_st == S_FIN);
  assign din        = r_din;
  assign state      = r_layer;
  assign short_err  = r_short_err;

`ifdef FEED_STATS_EN
  logic [15:0] r_ovr_cnt;
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ovr_cnt   <= 16'd0;
      r_stall_cnt <= 16'd0;
    end else if (r_st == S_IDLE && start) begin
      r_ovr_cnt   <= 16'd0;
      r_stall_cnt <= 16'd0;
    end else begin
      if (r_st == S_DRAIN && din_ready && r_ovr_cnt != 16'hFFFF)
        r_ovr_cnt <= r_ovr_cnt + 16'd1;
      if (r_st == S_STREAM && !din_ready && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign ovr_cnt   = r_ovr_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_conv_feeder.sv
// Directed/randomized bench for conv_feeder with RAM models and a stream-level reference.
module tb_conv_feeder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        layer = 1'b0;
  logic        wgt_rd;
  logic [9:0]  wgt_raddr;
  logic [31:0] wgt_rdata = 32'd0;
  logic        img_rd;
  logic [9:0]  img_raddr;
  logic [31:0] img_rdata = 32'd0;
  logic        conv_start, weight_en, weight, state, busy, done, short_err;
  logic [31:0] din;
  logic        din_ready = 1'b0;
  logic        conv_done = 1'b0;
`ifdef FEED_STATS_EN
  logic [15:0] ovr_cnt, stall_cnt;
`endif

  conv_feeder dut (
    .clk(clk), .rstn(rstn), .start(start), .layer(layer),
    .wgt_rd(wgt_rd), .wgt_raddr(wgt_raddr), .wgt_rdata(wgt_rdata),
    .img_rd(img_rd), .img_raddr(img_raddr), .img_rdata(img_rdata),
    .conv_start(conv_start), .weight_en(weight_en), .weight(weight),
    .din(din), .state(state), .din_ready(din_ready), .conv_done(conv_done),
    .busy(busy), .done(done), .short_err(short_err)
`ifdef FEED_STATS_EN
    , .ovr_cnt(ovr_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] wmem [0:31];
  logic [31:0] imem [0:783];
  logic [9:0]  rd_log  [0:4095];
  logic [9:0]  wrd_log [0:1023];
  int rd_cnt = 0;
  int wrd_cnt = 0;

  // Sync-read RAM models; every read address is logged in order.
  always @(posedge clk) begin
    if (wgt_rd) begin
      wgt_rdata <= wmem[wgt_raddr[4:0]];
      if (wrd_cnt < 1024) wrd_log[wrd_cnt] <= wgt_raddr;
      wrd_cnt <= wrd_cnt + 1;
    end
    if (img_rd) begin
      img_rdata <= (img_raddr < 10'd784) ? imem[img_raddr] : 32'hDEAD_BEEF;
      if (rd_cnt < 4096) rd_log[rd_cnt] <= img_raddr;
      rd_cnt <= rd_cnt + 1;
    end
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int first_chg, last_chg;
  logic [31:0] last_din;
  logic wq[$];
  logic [31:0] dq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (weight_en === 1'b1) wq.push_back(weight);
    if (din !== last_din) begin
      if (dq.size() == 0) first_chg = cyc;
      dq.push_back(din);
      last_din = din;
      last_chg = cyc;
    end
  endtask

  task automatic init_mem(input bit msb_one);
    logic [31:0] t;
    for (int i = 0; i < 32; i++) begin
      t = $urandom;
      if (msb_one) t[31] = 1'b1;
      wmem[i] = t;
    end
    for (int i = 0; i < 784; i++) begin
      t = $urandom;
      imem[i] = {t[31:21], 1'b1, t[19:10], 10'(i)};
    end
  endtask

  task automatic run_layer(input logic lay, input int dr_pct, input int early_at,
                           input int abort_at, input int drain_n, input logic drain_dr,
                           input logic mid_start);
    int n, exp_cnt, drain_left, done_cnt, base_rd, base_wrd, nrd, bad;
    logic cd_sent, busy_at_done, cs_at_done, st_at_done, aborted;
    n = lay ? 144 : 784;
    wq.delete();
    dq.delete();
    last_din = din;
    done_cnt = 0; cd_sent = 1'b0; aborted = 1'b0; drain_left = drain_n;
    busy_at_done = 1'b0; cs_at_done = 1'b1; st_at_done = ~lay;
    base_rd = rd_cnt; base_wrd = wrd_cnt;
    layer = lay; start = 1'b1;
    tick();
    chk("busy_rise", busy, 1);
    chk("conv_start_rise", conv_start, 1);
    chk("short_err_clear", short_err, 0);
    start = 1'b0; layer = ~lay;
    tick();
    chk("weight_en_latency", weight_en, 1);
    for (int t = 0; t < 4000 && done_cnt == 0; t++) begin
      din_ready = 1'b0; conv_done = 1'b0; start = 1'b0;
      if (abort_at != 0 && dq.size() == abort_at) begin
        aborted = 1'b1;
        break;
      end
      if (early_at != 0 && dq.size() == early_at) begin
        conv_done = ~cd_sent;
        cd_sent = 1'b1;
      end else if (dq.size() == n) begin
        if (drain_left > 0) begin
          din_ready = drain_dr;
          drain_left--;
        end else begin
          conv_done = ~cd_sent;
          cd_sent = 1'b1;
        end
      end else begin
        din_ready = ($urandom_range(99) < dr_pct);
      end
      if (mid_start && dq.size() == 50) start = 1'b1;
      tick();
      if (done === 1'b1) begin
        done_cnt++;
        busy_at_done = busy; cs_at_done = conv_start; st_at_done = state;
      end
    end
    din_ready = 1'b0; conv_done = 1'b0; start = 1'b0;
    if (!aborted) begin
      chk("done_pulse", done_cnt, 1);
      chk("busy_at_done", busy_at_done, 1);
      chk("conv_start_at_done", cs_at_done, 0);
      chk("state_latched", st_at_done, lay);
      tick();
      chk("done_width", done, 0);
      chk("busy_fall", busy, 0);
      chk("weight_en_cycles", wq.size(), 25);
      bad = 0;
      for (int i = 0; i < wq.size() && i < 25; i++)
        if (wq[i] !== ~wmem[i][31]) bad++;
      chk("weight_bits", bad, 0);
      bad = 0;
      for (int i = 0; i < wrd_cnt - base_wrd; i++)
        if (wrd_log[base_wrd + i] !== 10'(i)) bad++;
      chk("wgt_addr_seq", bad, 0);
      chk("wgt_reads", wrd_cnt - base_wrd, 25);
      exp_cnt = (early_at != 0) ? early_at : n;
      chk("pixel_count", dq.size(), exp_cnt);
      bad = 0;
      for (int k = 0; k < dq.size() && k < exp_cnt; k++)
        if (dq[k] !== imem[k]) bad++;
      chk("pixel_order", bad, 0);
      nrd = rd_cnt - base_rd;
      bad = 0;
      for (int j = 0; j < nrd; j++)
        if (rd_log[base_rd + j] !== 10'(j)) bad++;
      chk("img_addr_seq", bad, 0);
      if (early_at == 0) chk("img_reads", nrd, n);
      chk("short_err", short_err, (early_at != 0));
      if (dr_pct == 100 && early_at == 0) chk("no_bubbles", last_chg - first_chg, n - 1);
    end
  endtask

  initial begin
    init_mem(1'b1);
    #2;
    chk("reset_ctrl", {wgt_rd, wgt_raddr, img_rd, img_raddr, conv_start, weight_en,
                       weight, state, busy, done, short_err}, 0);
    chk("reset_din", din, 0);
    tick();
    rstn = 1'b1;
    tick();

    // kernel with all MSBs set, 28x28 image with din_ready held high
    run_layer(1'b0, 100, 0, 0, 2, 1'b0, 1'b0);

    // random kernel, 12x12 image, 50% din_ready, stray start while busy
    init_mem(1'b0);
    run_layer(1'b1, 50, 0, 0, 3, 1'b1, 1'b1);

    // early conv_done after 100 pixels, then a clean run clears short_err
    init_mem(1'b0);
    run_layer(1'b0, 100, 100, 0, 2, 1'b0, 1'b0);
    run_layer(1'b1, 80, 0, 0, 2, 1'b0, 1'b0);

    // asynchronous reset at pixel 300, then a fresh layer from address 0
    init_mem(1'b0);
    run_layer(1'b0, 100, 0, 300, 2, 1'b0, 1'b0);
    din_ready = 1'b0;
    #1 rstn = 1'b0;
    #1;
    chk("abort_ctrl", {wgt_rd, wgt_raddr, img_rd, img_raddr, conv_start, weight_en,
                       weight, state, busy, done, short_err}, 0);
    chk("abort_din", din, 0);
    tick();
    rstn = 1'b1;
    tick();
    run_layer(1'b0, 70, 0, 0, 2, 1'b0, 1'b0);

`ifdef FEED_STATS_EN
    for (int r = 0; r < 2; r++) begin
      init_mem(1'b0);
      run_layer(1'b1, 100, 0, 0, 7, 1'b1, 1'b0);
      chk("ovr_cnt", ovr_cnt, 7);
      chk("stall_cnt", stall_cnt, 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
